// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the parametrised single-clock FIFO.
package sync_fifo_pkg;

    // Width needed to index 'depth' distinct values; never narrower than 1 bit.
    function automatic int unsigned clog2_depth(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Write/read handshake and status bundle of the single-clock FIFO.
interface sync_fifo_param_if
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 45
) ();
    localparam int unsigned CW = clog2_depth(DEPTH + 1);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              clr_flags;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_flags,
        input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_flags,
        output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// Flop-array storage: one synchronous write port, one asynchronous read port.
module sync_fifo_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 45,
    parameter int unsigned AW     = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; occupancy tracking makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, standard/FWFT read, occupancy and sticky error flags.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 45,
    parameter bit          FWFT      = 1'b0,
    parameter int unsigned AF_THRESH = 40,
    parameter int unsigned AE_THRESH = 4
) (
    input logic                clk,
    input logic                arstn,
    sync_fifo_param_if.slave   bus
);
    localparam int unsigned AW = clog2_depth(DEPTH);
    localparam int unsigned CW = clog2_depth(DEPTH + 1);

    localparam fifo_status_t STATUS_RST = '{
        full: 1'b0, empty: 1'b1, almost_full: 1'b0,
        almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0
    };

    if (DATA_W < 1) begin : g_bad_data_w
        $fatal(1, "sync_fifo_param: DATA_W must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_param: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    fifo_status_t      status_q, status_d;
    logic              wr_acc_c, rd_acc_c;
    logic [DATA_W-1:0] ram_rd_data;

    // Wrap at DEPTH-1 explicitly so non-power-of-2 depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        status_d = status_q;

        wr_acc_c = bus.wr_en & ~status_q.full;
        rd_acc_c = bus.rd_en & ~status_q.empty;

        if (wr_acc_c) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_acc_c) rd_ptr_d = ptr_inc(rd_ptr_q);

        count_d = count_q + CW'(wr_acc_c) - CW'(rd_acc_c);

        status_d.full         = (count_d == CW'(DEPTH));
        status_d.empty        = (count_d == '0);
        status_d.almost_full  = (count_d >= CW'(AF_THRESH));
        status_d.almost_empty = (count_d <= CW'(AE_THRESH));
        // A new error event in the same cycle beats the clear.
        status_d.overflow     = (bus.wr_en & status_q.full)  | (status_q.overflow  & ~bus.clr_flags);
        status_d.underflow    = (bus.rd_en & status_q.empty) | (status_q.underflow & ~bus.clr_flags);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            status_q <= STATUS_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc_c),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rd_data)
    );

    if (FWFT) begin : g_fwft
        assign bus.rd_data = status_q.empty ? '0 : ram_rd_data;
    end else begin : g_std
        logic [DATA_W-1:0] rd_data_q, rd_data_d;

        always_comb begin
            rd_data_d = rd_data_q;
            if (rd_acc_c) rd_data_d = ram_rd_data;
        end

        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) rd_data_q <= '0;
            else        rd_data_q <= rd_data_d;
        end

        assign bus.rd_data = rd_data_q;
    end

    assign bus.count        = count_q;
    assign bus.full         = status_q.full;
    assign bus.empty        = status_q.empty;
    assign bus.almost_full  = status_q.almost_full;
    assign bus.almost_empty = status_q.almost_empty;
    assign bus.overflow     = status_q.overflow;
    assign bus.underflow    = status_q.underflow;
endmodule
